mq_bytein: RTL
==============

# mq_bytein

MQ arithmetic decoder byte-input stage: the read side of the MQ coder byte-out path. It pulls the compressed codeword one byte at a time from a valid/ready stream. It undoes 0xFF bit-stuffing, detects terminating markers (0xFF followed by a byte > 0x8F), and maintains the decoder's C register and bit counter CT (INITDEC/BYTEIN/RENORMD per ITU-T T.800 Annex C). The decoder core keeps A, compares against `chigh`, and issues `sub`/`shift` commands.

## Interface
- No parameters.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- byte_in  in  8  next codeword byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  stage accepts byte_in this cycle.
- init  in  1  one-cycle pulse: start new codeword segment.
- shift  in  1  request one-bit left shift of C (RENORMD step).
- sub  in  1  request Chigh -= sub_val.
- sub_val  in  16  value subtracted from Chigh.
- rdy  out  1  commands accepted this cycle.
- chigh  out  16  C[31:16].
- ct  out  4  remaining bits before next BYTEIN.
- marker  out  1  terminating marker reached.
- BP  out  16  count of bytes advanced past in this segment.

## Operation
- Registers: 32-bit C, 4-bit CT, 16-bit BP, marker flag, two-byte window cur/nxt with valid bits cur_v/nxt_v.
- States:
  - IDLE: after reset.
  - LOAD: fill the window.
  - INIT: one cycle.
  - READY.
- init pulse, any state, including mid-LOAD or READY:
  - next cycle: C=0, CT=0, BP=0, marker=0, cur_v=nxt_v=0, state LOAD.
  - Bytes already held in the window are discarded.
- byte_ready = (state is LOAD or READY) && !marker && (!cur_v || !nxt_v).
  - On byte_valid && byte_ready, the byte fills cur if empty, else nxt.
- LOAD → INIT when cur_v && nxt_v.
- BYTEIN(Cx) returns (add, newCT, adv):
  - cur≠0xFF: add = nxt<<8, CT=8, adv=1.
  - cur=0xFF, nxt≤0x8F: add = nxt<<9, CT=7, adv=1.
  - cur=0xFF, nxt>0x8F, or marker already set: add = 0xFF00, CT=8, adv=0, marker←1.
- Advance (adv=1): cur←nxt, nxt_v←0, BP←BP+1 (wraps at 0xFFFF).
- INIT cycle:
  - C ← ((cur<<16) + add)<<7.
  - CT ← newCT−7.
  - → READY.
- rdy = (state==READY) && (CT≠0 || nxt_v || marker).
- A command is accepted when (shift||sub) && rdy. Commands issued while rdy=0 are ignored; the core holds them until rdy.
- sub: Chigh ← Chigh − sub_val, modulo 2^16. There is no borrow into or out of Clow.
- shift, CT≠0: C ← C<<1, CT ← CT−1.
- shift, CT=0: BYTEIN and shift in the same cycle: C ← (C+add)<<1, CT ← newCT−1.
- sub and shift in the same cycle: subtract first, then shift the result.
- All C arithmetic is modulo 2^32; bits shifted out of C[31] are lost.
- After marker=1, no bytes are consumed until init.

## Timing
- Reset values: chigh=0, ct=0, BP=0, marker=0, rdy=0, byte_ready=0, state IDLE.
- All outputs are registered state or simple decodes of it; no combinational path from byte_in to chigh.
- Latency:
  - init → LOAD: 1 cycle.
  - Last window byte accepted → INIT: 1 cycle.
  - INIT → rdy=1: 1 cycle.
  - Minimum init-to-rdy with bytes presented back-to-back: 4 cycles.
  - Command result appears on chigh/ct the cycle after acceptance.
- Sustained throughput: one shift per cycle. nxt refills 1 cycle after an advance, so a stall occurs only if the source is late by more than 7 shifts.
- byte_ready never depends on byte_valid.

## Test plan
- Init with bytes 0x12, 0x34 → chigh=0x091A, ct=1, BP=1, rdy=1, marker=0.
- From test 1:
  - shift → chigh=0x1234, ct=0.
  - Present 0x56, then shift → chigh=0x2468, ct=7, BP=2.
- Init with bytes 0xFF, 0x7F (stuffed) → chigh=0x7FFF, ct=0, BP=1.
- Marker case:
  - Init with 0xFF, 0x90 → chigh=0x7FFF, ct=1, BP=0, marker=1, byte_ready=0.
  - Two shifts → chigh=0xFFFF, ct=7, BP still 0.
- Sub tests, from test 1 state:
  - sub 0x0100 → chigh=0x081A.
  - sub 0x1000 → chigh=0xF91A (wrap).
  - sub 0x0100 with shift in the same cycle → chigh=0x1034.
- Stall:
  - At ct=0, withhold byte_valid → rdy=0, shift ignored, C unchanged.
  - Supply the byte → rdy=1 the next cycle.
- Asynchronous reset:
  - Assert rst low mid-LOAD → all outputs go to reset values immediately, without waiting for clk.
- init mid-READY → BP=0, marker=0, window refilled from new bytes.

Source files
------------

// File: rtl/mq_bytein_if.sv
// mq_bytein_if: bundle between the MQ decoder core and the byte-input stage.
//
// Byte stream (source -> stage):
//   byte_in[7:0], byte_valid   next codeword byte and its qualifier
//   byte_ready                 stage takes byte_in on this cycle's rising edge
// Command path (core -> stage):
//   init                       one-cycle pulse, restart for a new segment
//   shift, sub, sub_val[15:0]  RENORMD shift / Chigh subtract requests
//   rdy                        commands are taken on this cycle's rising edge
// Status (stage -> core):
//   chigh[15:0]  C[31:16]      ct[3:0]  bits left before next BYTEIN
//   marker       terminating marker seen
//   BP[15:0]     bytes advanced past in this segment
//   state_dbg[1:0] FSM state (0 IDLE, 1 LOAD, 2 INIT, 3 READY)
//
// Handshake rule for both paths: a transfer happens on a rising edge where
// the qualifier (byte_valid, or shift/sub) and the acceptor's ready
// (byte_ready, or rdy) are both high. Ready never depends on the
// qualifier; the sender holds its request stable until it is taken.
interface mq_bytein_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        init;
  logic        shift;
  logic        sub;
  logic [15:0] sub_val;
  logic        rdy;
  logic [15:0] chigh;
  logic [3:0]  ct;
  logic        marker;
  logic [15:0] BP;
  logic [1:0]  state_dbg;

  modport master (
    output byte_in, byte_valid, init, shift, sub, sub_val,
    input  byte_ready, rdy, chigh, ct, marker, BP, state_dbg
  );

  modport slave (
    input  byte_in, byte_valid, init, shift, sub, sub_val,
    output byte_ready, rdy, chigh, ct, marker, BP, state_dbg
  );
endinterface

// File: rtl/mq_bytein.sv
// mq_bytein: byte-input stage of an MQ arithmetic decoder.
//
// Pulls codeword bytes from a valid/ready stream into a two-byte window
// (cur/nxt), removes 0xFF bit-stuffing, detects terminating markers
// (0xFF followed by a byte above 0x8F) and keeps the decoder's C register
// and bit counter CT. The decoder core owns A, compares it with chigh and
// issues sub/shift commands.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   mq_bytein_if.slave (byte stream, commands, status, state_dbg)
//
// All outputs are registers or decodes of registers; byte_in only reaches
// the window registers, never chigh, in the same cycle.
module mq_bytein (
  input  logic      clk,
  input  logic      rst,
  mq_bytein_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_INIT  = 2'd2,
    S_READY = 2'd3
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] c_q, c_d;
  logic [3:0]  ct_q, ct_d;
  logic [15:0] bp_q, bp_d;
  logic        marker_q, marker_d;
  logic [7:0]  cur_q, cur_d;
  logic [7:0]  nxt_q, nxt_d;
  logic        cur_v_q, cur_v_d;
  logic        nxt_v_q, nxt_v_d;

  logic        byte_ready;
  logic        byte_take;
  logic        rdy;
  logic        cmd_take;

  // BYTEIN result for the current window.
  logic [31:0] bi_add;
  logic [3:0]  bi_ct;
  logic        bi_adv;
  logic        bi_mark;

  logic [31:0] c_sub;
  logic [31:0] c_pre;

  // ------------------------------------------------------------------
  // Handshake decodes
  // ------------------------------------------------------------------
  assign byte_ready = ((state_q == S_LOAD) || (state_q == S_READY)) &&
                      !marker_q && (!cur_v_q || !nxt_v_q);
  assign byte_take  = byte_ready && bus.byte_valid;

  // At CT=0 a shift needs a BYTEIN, which needs nxt unless the marker path
  // (constant 0xFF00 feed) is already active.
  assign rdy      = (state_q == S_READY) &&
                    ((ct_q != 4'd0) || nxt_v_q || marker_q);
  assign cmd_take = rdy && (bus.shift || bus.sub);

  // ------------------------------------------------------------------
  // BYTEIN: what to add into C and how many bits the new byte yields.
  // A stuffed byte (after 0xFF) carries only 7 bits, hence the extra
  // shift by one and CT=7. Once a marker is seen, 1s are fed forever.
  // ------------------------------------------------------------------
  always_comb begin
    bi_add  = {16'h0000, nxt_q, 8'h00};
    bi_ct   = 4'd8;
    bi_adv  = 1'b1;
    bi_mark = 1'b0;
    if (marker_q || ((cur_q == 8'hFF) && (nxt_q > 8'h8F))) begin
      bi_add  = 32'h0000_FF00;
      bi_ct   = 4'd8;
      bi_adv  = 1'b0;
      bi_mark = 1'b1;
    end else if (cur_q == 8'hFF) begin
      bi_add  = {15'h0000, nxt_q, 9'h000};
      bi_ct   = 4'd7;
      bi_adv  = 1'b1;
    end
  end

  // Subtract touches only the high half; no borrow crosses into Clow.
  assign c_sub = {c_q[31:16] - bus.sub_val, c_q[15:0]};
  assign c_pre = bus.sub ? c_sub : c_q;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (bus.init) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_LOAD: begin
          // Go as soon as the byte completing the window is taken, so INIT
          // runs the cycle right after the last fill.
          if (cur_v_q && (nxt_v_q || byte_take)) begin
            state_d = S_INIT;
          end
        end
        S_INIT: begin
          state_d = S_READY;
        end
        S_READY: begin
          state_d = S_READY;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Datapath next values
  // ------------------------------------------------------------------
  always_comb begin
    c_d      = c_q;
    ct_d     = ct_q;
    bp_d     = bp_q;
    marker_d = marker_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    cur_v_d  = cur_v_q;
    nxt_v_d  = nxt_v_q;

    if (bus.init) begin
      // New segment: everything in the window, including a byte taken in
      // this very cycle, belongs to the old segment and is dropped.
      c_d      = 32'h0000_0000;
      ct_d     = 4'd0;
      bp_d     = 16'h0000;
      marker_d = 1'b0;
      cur_v_d  = 1'b0;
      nxt_v_d  = 1'b0;
    end else begin
      if (byte_take) begin
        if (!cur_v_q) begin
          cur_d   = bus.byte_in;
          cur_v_d = 1'b1;
        end else begin
          nxt_d   = bus.byte_in;
          nxt_v_d = 1'b1;
        end
      end

      case (state_q)
        S_INIT: begin
          // INITDEC: C = cur<<16, BYTEIN, then C<<=7 and CT-=7.
          c_d  = ({8'h00, cur_q, 16'h0000} + bi_add) << 7;
          ct_d = bi_ct - 4'd7;
          if (bi_adv) begin
            cur_d   = nxt_q;
            nxt_v_d = 1'b0;
            bp_d    = bp_q + 16'd1;
          end
          if (bi_mark) begin
            marker_d = 1'b1;
          end
        end
        S_READY: begin
          if (cmd_take) begin
            if (!bus.shift) begin
              c_d = c_pre;
            end else if (ct_q != 4'd0) begin
              c_d  = c_pre << 1;
              ct_d = ct_q - 4'd1;
            end else begin
              // CT exhausted: BYTEIN folded into the same shift cycle.
              // An advance only happens with nxt_v set, when byte_ready
              // is low, so it never collides with a window fill.
              c_d  = (c_pre + bi_add) << 1;
              ct_d = bi_ct - 4'd1;
              if (bi_adv) begin
                cur_d   = nxt_q;
                nxt_v_d = 1'b0;
                bp_d    = bp_q + 16'd1;
              end
              if (bi_mark) begin
                marker_d = 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q      <= 32'h0000_0000;
      ct_q     <= 4'd0;
      bp_q     <= 16'h0000;
      marker_q <= 1'b0;
      cur_q    <= 8'h00;
      nxt_q    <= 8'h00;
      cur_v_q  <= 1'b0;
      nxt_v_q  <= 1'b0;
    end else begin
      c_q      <= c_d;
      ct_q     <= ct_d;
      bp_q     <= bp_d;
      marker_q <= marker_d;
      cur_q    <= cur_d;
      nxt_q    <= nxt_d;
      cur_v_q  <= cur_v_d;
      nxt_v_q  <= nxt_v_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.byte_ready = byte_ready;
  assign bus.rdy        = rdy;
  assign bus.chigh      = c_q[31:16];
  assign bus.ct         = ct_q;
  assign bus.marker     = marker_q;
  assign bus.BP         = bp_q;
  assign bus.state_dbg  = state_q;

endmodule
